// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with a DEPTH-entry, PC-tagged prefetch queue.
// Decode redirects flush the queue, restart fetch, and drop any response still in flight.
`default_nettype none

module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_en,
   output logic [XLEN-1:0]          imem_addr,
   input  logic [XLEN-1:0]          imem_rdata,
   input  logic                     redirect_valid,
   input  logic [XLEN-1:0]          redirect_pc,
   output logic                     instr_valid,
   input  logic                     instr_ready,
   output logic [XLEN-1:0]          instrF,
   output logic [XLEN-1:0]          pcF,
   output logic [XLEN-1:0]          pc_plus4F,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int             PW   = $clog2(DEPTH);
   localparam int             CW   = PW + 1;
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_resp_q;
   logic            inflight_q;
   logic [CW-1:0]   count;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [XLEN-1:0] tag_mem   [DEPTH];

   logic issue;
   logic push;
   logic pop;

   // An outstanding request reserves a slot; a same-cycle pop earns no credit.
   always_comb begin
      issue = rst & (redirect_valid | ((count + CW'(inflight_q)) < FULL));
      push  = inflight_q & ~redirect_valid;
      pop   = instr_valid & instr_ready & ~redirect_valid;
   end

   assign imem_en     = issue;
   assign imem_addr   = redirect_valid ? redirect_pc : pc_q;
   assign instr_valid = (count != '0);
   assign occupancy   = count;
   assign instrF      = instr_valid ? instr_mem[rd_ptr] : '0;
   assign pcF         = instr_valid ? tag_mem[rd_ptr]   : '0;
   assign pc_plus4F   = instr_valid ? (pcF + XLEN'(4))  : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= RESET_PC;
         pc_resp_q  <= '0;
         inflight_q <= 1'b0;
         count      <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            pc_q      <= imem_addr + XLEN'(4);
            pc_resp_q <= imem_addr;
         end
         if (redirect_valid) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
               count <= count + CW'(1);
            else if (!push && pop)
               count <= count - CW'(1);
         end
      end
   end

   // Payload storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= imem_rdata;
         tag_mem[wr_ptr]   <= pc_resp_q;
      end
   end

endmodule

`default_nettype wire
